// File: rtl/min_select_stream_pkg.sv
// Shared constants and types for the streaming minimum selector on the search datapath.
package min_select_stream_pkg;

  localparam int COST_W = 8;
  localparam int TAG_W  = 8;

  localparam logic [COST_W-1:0] COST_MAX = '1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/min_select_stream_lane_reduce.sv
// Combinational LANES-input minimum: smallest masked-in cost, lower lane index wins ties.
module min_lane_reduce
  import min_select_stream_pkg::*;
#(
  parameter int W     = COST_W,
  parameter int TW    = TAG_W,
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]    mask,
  input  logic [LANES*W-1:0]  cost,
  input  logic [LANES*TW-1:0] tag,
  output logic                found,
  output logic [W-1:0]        min_cost,
  output logic [TW-1:0]       min_tag
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    min_cost = '1;
    min_tag  = '0;
    // Strict '<' keeps the lower lane on ties; masked-out lanes are never looked at.
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] && (!found || cost[i*W +: W] < min_cost)) begin
        found    = 1'b1;
        min_cost = cost[i*W +: W];
        min_tag  = tag[i*TW +: TW];
      end
    end
  end

endmodule

// File: rtl/min_select_stream.sv
// Streaming minimum selector: folds a frame of (cost, tag) beats into one registered result.
module min_select_stream
  import min_select_stream_pkg::*;
#(
  parameter int W     = COST_W,
  parameter int TW    = TAG_W,
  parameter int LANES = 2,
  parameter int CW    = 16
) (
  input  logic                p_reset,
  input  logic                m_clock,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [LANES-1:0]    in_mask,
  input  logic [LANES*W-1:0]  in_cost,
  input  logic [LANES*TW-1:0] in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_cost,
  output logic [TW-1:0]       out_tag,
  output logic [CW-1:0]       out_count,
  output logic                out_none
);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_cost_q, acc_cost_d;
  logic [TW-1:0]  acc_tag_q, acc_tag_d;
  logic           acc_found_q, acc_found_d;
  logic [CW-1:0]  acc_count_q, acc_count_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_cost_q, out_cost_d;
  logic [TW-1:0]  out_tag_q, out_tag_d;
  logic [CW-1:0]  out_count_q, out_count_d;
  logic           out_none_q, out_none_d;

  logic           beat_found;
  logic [W-1:0]   beat_cost;
  logic [TW-1:0]  beat_tag;
  logic           accept;
  logic           take;
  logic [W-1:0]   fold_cost;
  logic [TW-1:0]  fold_tag;
  logic           fold_found;
  logic [CW:0]    pop;
  logic [CW:0]    sum;
  logic [CW-1:0]  fold_count;

  min_lane_reduce #(
    .W     (W),
    .TW    (TW),
    .LANES (LANES)
  ) u_reduce (
    .mask     (in_mask),
    .cost     (in_cost),
    .tag      (in_tag),
    .found    (beat_found),
    .min_cost (beat_cost),
    .min_tag  (beat_tag)
  );

  assign in_ready = (state_q == ACC);
  assign accept   = in_valid & in_ready;

  // Earlier beat keeps the accumulator on equal cost.
  always_comb begin
    take       = beat_found && (!acc_found_q || beat_cost < acc_cost_q);
    fold_cost  = take ? beat_cost : acc_cost_q;
    fold_tag   = take ? beat_tag  : acc_tag_q;
    fold_found = acc_found_q | beat_found;

    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + (CW+1)'(in_mask[i]);
    end
    sum        = {1'b0, acc_count_q} + pop;
    fold_count = sum[CW] ? '1 : sum[CW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_cost_d  = acc_cost_q;
    acc_tag_d   = acc_tag_q;
    acc_found_d = acc_found_q;
    acc_count_d = acc_count_q;
    out_valid_d = out_valid_q;
    out_cost_d  = out_cost_q;
    out_tag_d   = out_tag_q;
    out_count_d = out_count_q;
    out_none_d  = out_none_q;

    case (state_q)
      ACC: begin
        if (accept) begin
          if (in_last) begin
            out_valid_d = 1'b1;
            out_cost_d  = fold_cost;
            out_tag_d   = fold_tag;
            out_count_d = fold_count;
            out_none_d  = !fold_found;
            acc_cost_d  = '1;
            acc_tag_d   = '0;
            acc_found_d = 1'b0;
            acc_count_d = '0;
            state_d     = HOLD;
          end else begin
            acc_cost_d  = fold_cost;
            acc_tag_d   = fold_tag;
            acc_found_d = fold_found;
            acc_count_d = fold_count;
          end
        end
      end
      HOLD: begin
        // out_valid is always high here, so out_ready alone completes the handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // NOTE: state uses non-blocking assignments and every register has an async reset value.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q     <= ACC;
      acc_cost_q  <= '1;
      acc_tag_q   <= '0;
      acc_found_q <= 1'b0;
      acc_count_q <= '0;
      out_valid_q <= 1'b0;
      out_cost_q  <= '0;
      out_tag_q   <= '0;
      out_count_q <= '0;
      out_none_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cost_q  <= acc_cost_d;
      acc_tag_q   <= acc_tag_d;
      acc_found_q <= acc_found_d;
      acc_count_q <= acc_count_d;
      out_valid_q <= out_valid_d;
      out_cost_q  <= out_cost_d;
      out_tag_q   <= out_tag_d;
      out_count_q <= out_count_d;
      out_none_q  <= out_none_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_cost  = out_cost_q;
  assign out_tag   = out_tag_q;
  assign out_count = out_count_q;
  assign out_none  = out_none_q;

endmodule

// File: tb/tb_min_select_stream.sv
// Self-checking bench for min_select_stream: vector table, scoreboard queue, multi-beat corner cases.
module tb_min_select_stream;

  logic        p_reset;
  logic        m_clock;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic        in_last;
  logic [1:0]  in_mask;
  logic [15:0] in_cost;
  logic [15:0] in_tag;
  logic        out_valid, out_valid_s;
  logic        out_ready;
  logic [7:0]  out_cost, out_cost_s;
  logic [7:0]  out_tag, out_tag_s;
  logic [15:0] out_count;
  logic [3:0]  out_count_s;
  logic        out_none, out_none_s;

  int tests = 0;
  int fails = 0;

  min_select_stream dut (
    .p_reset(p_reset), .m_clock(m_clock),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mask(in_mask), .in_cost(in_cost), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cost(out_cost), .out_tag(out_tag), .out_count(out_count), .out_none(out_none)
  );

  // Same stream, 4-bit counter: only the count differs from the main instance.
  min_select_stream #(.CW(4)) dut_sat (
    .p_reset(p_reset), .m_clock(m_clock),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
    .in_mask(in_mask), .in_cost(in_cost), .in_tag(in_tag),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_cost(out_cost_s), .out_tag(out_tag_s), .out_count(out_count_s), .out_none(out_none_s)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  typedef struct {
    logic [1:0] mask;
    logic [7:0] c0, c1, t0, t1;
    logic [7:0] ec, et;
    int         ecnt;
    logic       en;
  } vec_t;

  typedef struct {
    logic [7:0]  cost;
    logic [7:0]  tag;
    logic [15:0] count;
    logic [3:0]  count_sat;
    logic        none;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] cost, input logic [7:0] tag, input int count,
                          input logic none);
    exp_t e;
    e.cost      = cost;
    e.tag       = tag;
    e.count     = 16'(count);
    e.count_sat = (count > 15) ? 4'd15 : 4'(count);
    e.none      = none;
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input logic last, input logic [1:0] mask,
                           input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] t0, input logic [7:0] t1);
    int n;
    in_valid = 1'b1;
    in_last  = last;
    in_mask  = mask;
    in_cost  = {c1, c0};
    in_tag   = {t1, t0};
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge m_clock); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL beat_accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge m_clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mask  = 2'b00;
  endtask

  // Waits for a result, compares against the scoreboard head, optionally holds
  // backpressure (with junk input offered) before completing the handshake.
  task automatic get_result(input string name, input int hold_cycles);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge m_clock); #1;
      n++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL %s_timeout: out_valid stayed 0, expected 1", name);
      return;
    end
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s_scoreboard: result with no expectation queued, expected one", name);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_cost"},  32'(out_cost),  32'(e.cost));
    check({name, "_tag"},   32'(out_tag),   32'(e.tag));
    check({name, "_count"}, 32'(out_count), 32'(e.count));
    check({name, "_none"},  32'(out_none),  32'(e.none));
    check({name, "_count_sat"}, 32'(out_count_s), 32'(e.count_sat));
    if (hold_cycles > 0) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_mask  = 2'b11;
      in_cost  = 16'h0000;
      in_tag   = 16'hDEAD;
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge m_clock); #1;
      check({name, "_hold_in_ready"},  32'(in_ready),  32'd0);
      check({name, "_hold_out_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_cost"},      32'(out_cost),  32'(e.cost));
      check({name, "_hold_tag"},       32'(out_tag),   32'(e.tag));
    end
    out_ready = 1'b1;
    @(posedge m_clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_mask   = 2'b00;
    check({name, "_post_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_post_in_ready"},  32'(in_ready),  32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{mask: 2'b11, c0: 8'd5,   c1: 8'd9,   t0: 8'h01, t1: 8'h02, ec: 8'd5,   et: 8'h01, ecnt: 2, en: 1'b0};
    vecs[1] = '{mask: 2'b10, c0: 8'd0,   c1: 8'd6,   t0: 8'hEE, t1: 8'h11, ec: 8'd6,   et: 8'h11, ecnt: 1, en: 1'b0};
    vecs[2] = '{mask: 2'b01, c0: 8'hFF,  c1: 8'd0,   t0: 8'h33, t1: 8'h44, ec: 8'hFF,  et: 8'h33, ecnt: 1, en: 1'b0};
    vecs[3] = '{mask: 2'b11, c0: 8'd4,   c1: 8'd4,   t0: 8'h55, t1: 8'h66, ec: 8'd4,   et: 8'h55, ecnt: 2, en: 1'b0};
    vecs[4] = '{mask: 2'b00, c0: 8'd1,   c1: 8'd2,   t0: 8'h77, t1: 8'h88, ec: 8'hFF,  et: 8'h00, ecnt: 0, en: 1'b1};
    vecs[5] = '{mask: 2'b11, c0: 8'hFF,  c1: 8'hFE,  t0: 8'h12, t1: 8'h34, ec: 8'hFE,  et: 8'h34, ecnt: 2, en: 1'b0};

    p_reset   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_mask   = 2'b00;
    in_cost   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge m_clock);
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_cost",  32'(out_cost),  32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);
    check("reset_out_none",  32'(out_none),  32'd0);
    p_reset = 1'b1;
    @(posedge m_clock); #1;

    // Single-beat frames from the table.
    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i].ec, vecs[i].et, vecs[i].ecnt, vecs[i].en);
      send_beat(1'b1, vecs[i].mask, vecs[i].c0, vecs[i].c1, vecs[i].t0, vecs[i].t1);
      check($sformatf("vec%0d_latency", i), 32'(out_valid), 32'd1);
      get_result($sformatf("vec%0d", i), 0);
    end

    // Three beats with cost ties across beats: first occurrence of 3 (tag B) wins.
    push_exp(8'd3, 8'h0B, 6, 1'b0);
    send_beat(1'b0, 2'b11, 8'd7, 8'd3, 8'h0A, 8'h0B);
    check("multi_mid_no_valid", 32'(out_valid), 32'd0);
    send_beat(1'b0, 2'b11, 8'd3, 8'd8, 8'h0C, 8'h0D);
    send_beat(1'b1, 2'b11, 8'd4, 8'd3, 8'h0E, 8'h0F);
    get_result("multi", 0);

    // Empty frame over two beats.
    push_exp(8'hFF, 8'h00, 0, 1'b1);
    send_beat(1'b0, 2'b00, 8'd1, 8'd1, 8'h99, 8'h99);
    send_beat(1'b1, 2'b00, 8'd2, 8'd2, 8'h99, 8'h99);
    get_result("empty", 0);

    // Backpressure, then an independent follow-up frame.
    push_exp(8'd2, 8'h21, 2, 1'b0);
    send_beat(1'b1, 2'b11, 8'd2, 8'd7, 8'h21, 8'h22);
    get_result("bp", 5);
    push_exp(8'd8, 8'h02, 2, 1'b0);
    send_beat(1'b1, 2'b11, 8'd9, 8'd8, 8'h01, 8'h02);
    get_result("bp_next", 0);

    // Reset mid-frame: partial minimum of 1 must not leak into the next frame.
    send_beat(1'b0, 2'b11, 8'd1, 8'd1, 8'hAA, 8'hAB);
    send_beat(1'b0, 2'b11, 8'd1, 8'd1, 8'hAC, 8'hAD);
    #2 p_reset = 1'b0;
    #1;
    check("rst_mid_in_ready",  32'(in_ready),    32'd1);
    check("rst_mid_out_valid", 32'(out_valid),   32'd0);
    check("rst_mid_out_cost",  32'(out_cost),    32'd0);
    check("rst_mid_out_tag",   32'(out_tag),     32'd0);
    check("rst_mid_out_count", 32'(out_count),   32'd0);
    check("rst_mid_out_none",  32'(out_none),    32'd0);
    check("rst_mid_count_sat", 32'(out_count_s), 32'd0);
    @(posedge m_clock); #1;
    p_reset = 1'b1;
    @(posedge m_clock); #1;
    push_exp(8'd50, 8'h9A, 1, 1'b0);
    send_beat(1'b1, 2'b01, 8'd50, 8'd0, 8'h9A, 8'h00);
    get_result("rst_fresh", 0);

    // Nine full beats: 18 candidates, 4-bit counter saturates at 15.
    push_exp(8'd12, 8'd8, 18, 1'b0);
    for (int i = 0; i < 9; i++) begin
      send_beat(i == 8, 2'b11, 8'(20 - i), 8'd30, 8'(i), 8'hF0);
    end
    get_result("sat", 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
